// File: rtl/serial_to_parallel_8bit.sv
// rtl/serial_to_parallel_8bit.sv - strobe-qualified serial-in, parallel-out word assembler
module serial_to_parallel_8bit #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             bit_take;
    logic             last_bit;
    logic             arm;

    // next shift-register value; also the word published on the final bit so
    // data_out carries that bit rather than the stale register contents
    always_comb begin
        shreg_shifted = shreg;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[WIDTH-2:0], sin};
        end else begin
            shreg_shifted = {sin, shreg[WIDTH-1:1]};
        end
    end

    assign bit_take = (state == SHIFT) && sin_valid;
    assign last_bit = bit_take && (cnt == CW'(WIDTH - 1));
    assign arm      = ((state == IDLE) || (state == DONE)) && start;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; start is only honoured outside SHIFT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: clear on arming, shift on strobed bits, publish on the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else if (arm) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bit_take) begin
            shreg <= shreg_shifted;
            if (last_bit) begin
                data_out <= shreg_shifted;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // status outputs decode directly from the registered state
    always_comb begin
        busy       = (state == SHIFT);
        data_valid = (state == DONE);
    end

endmodule
